// File: rtl/axi3_icn_pkg.sv
// Shared state, target and response encodings for the AXI3 interconnect family.
// Used by both the read and the write interconnects.
package axi3_icn_pkg;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DERR} icn_state_t;
    typedef enum logic [1:0] {TGT_S0, TGT_S1, TGT_NONE} tgt_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // The top address nibble picks the slave; anything else gets a local DECERR.
    function automatic tgt_t decode_target(input logic [3:0] region,
                                           input logic [3:0] s0_base,
                                           input logic [3:0] s1_base);
        if (region == s0_base)
            return TGT_S0;
        else if (region == s1_base)
            return TGT_S1;
        else
            return TGT_NONE;
    endfunction

endpackage

// File: rtl/axi3_read_interconnect_if.sv
// AXI3 read-path bundle (AR + R channels) for one master or slave attachment.
// The interconnect sees its masters through the slave modport and vice versa.
interface axi3_read_interconnect_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic [ADDR_W-1:0] ARADDR;
    logic              ARVALID;
    logic              ARREADY;
    logic [3:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY;
    logic              RLAST;

    modport master (
        output ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, RREADY,
        input  ARREADY, RDATA, RRESP, RVALID, RLAST
    );

    modport slave (
        input  ARADDR, ARVALID, ARLEN, ARSIZE, ARBURST, RREADY,
        output ARREADY, RDATA, RRESP, RVALID, RLAST
    );

endinterface

// File: rtl/axi3_rr_arbiter_2.sv
// Two-way round-robin arbiter; on contention the master that did not win last time wins.
// last_grant resets to 1 so master 0 wins the first contention.
module axi3_rr_arbiter_2 (
    input  logic       ACLK,
    input  logic       ARESETn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_valid,
    output logic       grant_id
);

    logic last_grant;

    always_comb begin
        grant_valid = |req;
        grant_id    = 1'b0;
        if (req == 2'b11)
            grant_id = ~last_grant;
        else if (req == 2'b10)
            grant_id = 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn)
            last_grant <= 1'b1;
        else if (advance)
            last_grant <= grant_id;
    end

endmodule

// File: rtl/axi3_read_interconnect.sv
// 2x2 AXI3 read interconnect: round-robin AR grant, one burst in flight, local DECERR responder.
// Optional AXI3_RD_RLAST_GEN_EN: generate RLAST from the beat counter and flag slave RLAST mismatches.
module axi3_read_interconnect
    import axi3_icn_pkg::*;
#(
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 32,
    parameter logic [3:0] S0_BASE = 4'h0,
    parameter logic [3:0] S1_BASE = 4'h1
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    axi3_read_interconnect_if.slave   m0,
    axi3_read_interconnect_if.slave   m1,
    axi3_read_interconnect_if.master  s0,
    axi3_read_interconnect_if.master  s1,
    output logic                      PROT_ERR
);

    icn_state_t state, state_next;

    logic              grant_valid, grant_id, grant_take;
    logic              mst;
    tgt_t              tgt, req_tgt;
    logic              tgt_idx;
    logic [ADDR_W-1:0] ar_addr, req_addr;
    logic [3:0]        ar_len, req_len, beat_cnt;
    logic [2:0]        ar_size, req_size;
    logic [1:0]        ar_burst, req_burst;

    logic              m_rready, s_arready, s_rvalid, s_rlast;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;
    logic              cnt_last, burst_last, beat_hs, cnt_step;

    logic [1:0]        m_arready, s_arvalid, s_rready;
    logic              r_valid, r_last;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;

    axi3_rr_arbiter_2 u_arb (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .req         ({m1.ARVALID, m0.ARVALID}),
        .advance     (grant_take),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign grant_take = (state == IDLE) && grant_valid;
    assign req_addr   = grant_id ? m1.ARADDR  : m0.ARADDR;
    assign req_len    = grant_id ? m1.ARLEN   : m0.ARLEN;
    assign req_size   = grant_id ? m1.ARSIZE  : m0.ARSIZE;
    assign req_burst  = grant_id ? m1.ARBURST : m0.ARBURST;
    assign req_tgt    = decode_target(req_addr[ADDR_W-1 -: 4], S0_BASE, S1_BASE);

    assign tgt_idx   = (tgt == TGT_S1);
    assign m_rready  = mst ? m1.RREADY : m0.RREADY;
    assign s_arready = tgt_idx ? s1.ARREADY : s0.ARREADY;
    assign s_rvalid  = tgt_idx ? s1.RVALID  : s0.RVALID;
    assign s_rlast   = tgt_idx ? s1.RLAST   : s0.RLAST;
    assign s_rdata   = tgt_idx ? s1.RDATA   : s0.RDATA;
    assign s_rresp   = tgt_idx ? s1.RRESP   : s0.RRESP;
    assign cnt_last  = (beat_cnt == ar_len);
    assign beat_hs   = s_rvalid && m_rready;

`ifdef AXI3_RD_RLAST_GEN_EN
    assign burst_last = cnt_last;
    assign cnt_step   = ((state == DATA) && beat_hs) || ((state == DERR) && m_rready);
`else
    assign burst_last = s_rlast;
    assign cnt_step   = (state == DERR) && m_rready;
`endif

    always_ff @(posedge ACLK) begin
        if (!ARESETn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = (req_tgt == TGT_NONE) ? DERR : ADDR;
            ADDR:    if (s_arready) state_next = DATA;
            DATA:    if (beat_hs && burst_last) state_next = IDLE;
            DERR:    if (m_rready && cnt_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured in the grant cycle so the slave sees a stable AR.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            mst      <= 1'b0;
            tgt      <= TGT_NONE;
            ar_addr  <= '0;
            ar_len   <= '0;
            ar_size  <= '0;
            ar_burst <= '0;
            beat_cnt <= '0;
        end else if (grant_take) begin
            mst      <= grant_id;
            tgt      <= req_tgt;
            ar_addr  <= req_addr;
            ar_len   <= req_len;
            ar_size  <= req_size;
            ar_burst <= req_burst;
            beat_cnt <= '0;
        end else if (cnt_step) begin
            beat_cnt <= cnt_last ? 4'd0 : beat_cnt + 4'd1;
        end
    end

`ifdef AXI3_RD_RLAST_GEN_EN
    always_ff @(posedge ACLK) begin
        if (!ARESETn)
            PROT_ERR <= 1'b0;
        else if ((state == DATA) && beat_hs && (s_rlast != cnt_last))
            PROT_ERR <= 1'b1;
    end
`else
    assign PROT_ERR = 1'b0;
`endif

    always_comb begin
        m_arready = '0;
        s_arvalid = '0;
        s_rready  = '0;
        r_valid   = 1'b0;
        r_data    = '0;
        r_resp    = RESP_OKAY;
        r_last    = 1'b0;
        case (state)
            IDLE: if (grant_valid && ARESETn) m_arready[grant_id] = 1'b1;
            ADDR: s_arvalid[tgt_idx] = 1'b1;
            DATA: begin
                r_valid           = s_rvalid;
                r_data            = s_rdata;
                r_resp            = s_rresp;
                r_last            = burst_last;
                s_rready[tgt_idx] = m_rready;
            end
            DERR: begin
                r_valid = 1'b1;
                r_resp  = RESP_DECERR;
                r_last  = cnt_last;
            end
            default: ;
        endcase
    end

    assign m0.ARREADY = m_arready[0];
    assign m1.ARREADY = m_arready[1];
    assign m0.RVALID  = r_valid && !mst;
    assign m1.RVALID  = r_valid && mst;
    assign m0.RLAST   = r_last && !mst;
    assign m1.RLAST   = r_last && mst;
    assign m0.RDATA   = mst ? '0 : r_data;
    assign m1.RDATA   = mst ? r_data : '0;
    assign m0.RRESP   = mst ? 2'b00 : r_resp;
    assign m1.RRESP   = mst ? r_resp : 2'b00;

    assign s0.ARVALID = s_arvalid[0];
    assign s1.ARVALID = s_arvalid[1];
    assign s0.RREADY  = s_rready[0];
    assign s1.RREADY  = s_rready[1];
    assign s0.ARADDR  = ar_addr;
    assign s1.ARADDR  = ar_addr;
    assign s0.ARLEN   = ar_len;
    assign s1.ARLEN   = ar_len;
    assign s0.ARSIZE  = ar_size;
    assign s1.ARSIZE  = ar_size;
    assign s0.ARBURST = ar_burst;
    assign s1.ARBURST = ar_burst;

endmodule

// File: tb/tb_axi3_read_interconnect.sv
// Directed self-checking bench for axi3_read_interconnect; slaves and masters are driven by hand.
// Define AXI3_RD_RLAST_GEN_EN to also exercise generated RLAST and PROT_ERR.
module tb_axi3_read_interconnect;

    logic ACLK = 1'b0;
    logic ARESETn;
    logic PROT_ERR;
    int   tests_run = 0;
    int   tests_failed = 0;

    axi3_read_interconnect_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    axi3_read_interconnect_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    axi3_read_interconnect_if #(.ADDR_W(32), .DATA_W(32)) s0_if ();
    axi3_read_interconnect_if #(.ADDR_W(32), .DATA_W(32)) s1_if ();

    axi3_read_interconnect #(
        .ADDR_W (32),
        .DATA_W (32),
        .S0_BASE(4'h0),
        .S1_BASE(4'h1)
    ) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .m0      (m0_if),
        .m1      (m1_if),
        .s0      (s0_if),
        .s1      (s1_if),
        .PROT_ERR(PROT_ERR)
    );

    always #5 ACLK = ~ACLK;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge ACLK);
        #1;
    endtask

    task automatic applyStimulus(input int m, input logic v, input logic [31:0] addr, input logic [3:0] len);
        if (m == 1) begin
            m1_if.ARVALID = v; m1_if.ARADDR = addr; m1_if.ARLEN = len;
            m1_if.ARSIZE = 3'd2; m1_if.ARBURST = 2'b01;
        end else begin
            m0_if.ARVALID = v; m0_if.ARADDR = addr; m0_if.ARLEN = len;
            m0_if.ARSIZE = 3'd2; m0_if.ARBURST = 2'b01;
        end
    endtask

    task automatic setSlaveR(input int s, input logic v, input logic [31:0] d, input logic l);
        if (s == 1) begin
            s1_if.RVALID = v; s1_if.RDATA = d; s1_if.RLAST = l; s1_if.RRESP = 2'b00;
        end else begin
            s0_if.RVALID = v; s0_if.RDATA = d; s0_if.RLAST = l; s0_if.RRESP = 2'b00;
        end
    endtask

    task automatic setSlaveArready(input int s, input logic r);
        if (s == 1) s1_if.ARREADY = r;
        else        s0_if.ARREADY = r;
    endtask

    task automatic setMasterRready(input int m, input logic r);
        if (m == 1) m1_if.RREADY = r;
        else        m0_if.RREADY = r;
    endtask

    function automatic logic mArready(input int m);
        return (m == 1) ? m1_if.ARREADY : m0_if.ARREADY;
    endfunction
    function automatic logic mRvalid(input int m);
        return (m == 1) ? m1_if.RVALID : m0_if.RVALID;
    endfunction
    function automatic logic mRlast(input int m);
        return (m == 1) ? m1_if.RLAST : m0_if.RLAST;
    endfunction
    function automatic logic [31:0] mRdata(input int m);
        return (m == 1) ? m1_if.RDATA : m0_if.RDATA;
    endfunction
    function automatic logic [1:0] mRresp(input int m);
        return (m == 1) ? m1_if.RRESP : m0_if.RRESP;
    endfunction
    function automatic logic sArvalid(input int s);
        return (s == 1) ? s1_if.ARVALID : s0_if.ARVALID;
    endfunction
    function automatic logic [31:0] sAraddr(input int s);
        return (s == 1) ? s1_if.ARADDR : s0_if.ARADDR;
    endfunction
    function automatic logic [3:0] sArlen(input int s);
        return (s == 1) ? s1_if.ARLEN : s0_if.ARLEN;
    endfunction
    function automatic logic sRready(input int s);
        return (s == 1) ? s1_if.RREADY : s0_if.RREADY;
    endfunction

    // Called in an IDLE cycle with ARVALID already up; expects master m to win and drops its request.
    task automatic grantCheck(input int m);
        #1;
        checkOutput("grant_winner_arready", mArready(m), 1);
        checkOutput("grant_loser_arready", mArready(1 - m), 0);
        stepCycle();
        applyStimulus(m, 1'b0, 32'h0, 4'h0);
    endtask

    task automatic addrPhase(input int s, input logic [31:0] addr, input logic [3:0] len, input int delay);
        for (int k = 0; k <= delay; k++) begin
            setSlaveArready(s, k == delay);
            #1;
            checkOutput("s_arvalid", sArvalid(s), 1);
            checkOutput("s_araddr", sAraddr(s), addr);
            checkOutput("s_arlen", sArlen(s), len);
            checkOutput("other_s_arvalid", sArvalid(1 - s), 0);
            checkOutput("addr_no_arready", mArready(0) | mArready(1), 0);
            stepCycle();
        end
        setSlaveArready(s, 1'b0);
    endtask

    task automatic serveBurst(input int m, input int s, input int nbeats, input logic [31:0] dbase);
        setMasterRready(m, 1'b1);
        for (int i = 0; i < nbeats; i++) begin
            setSlaveR(s, 1'b1, dbase + i, i == nbeats - 1);
            #1;
            checkOutput("beat_rvalid", mRvalid(m), 1);
            checkOutput("beat_rdata", mRdata(m), dbase + i);
            checkOutput("beat_rlast", mRlast(m), i == nbeats - 1);
            checkOutput("beat_rresp", mRresp(m), 2'b00);
            checkOutput("other_m_rvalid", mRvalid(1 - m), 0);
            checkOutput("s_rready", sRready(s), 1);
            stepCycle();
        end
        setSlaveR(s, 1'b0, 32'h0, 1'b0);
        setMasterRready(m, 1'b0);
        #1;
        checkOutput("burst_end_rvalid", mRvalid(m), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int beat;
        int got;

        applyStimulus(0, 1'b0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 32'h0, 4'h0);
        setSlaveR(0, 1'b0, 32'h0, 1'b0);
        setSlaveR(1, 1'b0, 32'h0, 1'b0);
        setSlaveArready(0, 1'b0);
        setSlaveArready(1, 1'b0);
        setMasterRready(0, 1'b0);
        setMasterRready(1, 1'b0);

        // Reset: a request during reset must not be accepted.
        ARESETn = 1'b0;
        stepCycle();
        stepCycle();
        applyStimulus(0, 1'b1, 32'h0000_0040, 4'd3);
        #1;
        checkOutput("rst_m0_arready", mArready(0), 0);
        checkOutput("rst_s0_arvalid", sArvalid(0), 0);
        checkOutput("rst_m0_rvalid", mRvalid(0), 0);
        checkOutput("rst_s0_araddr", sAraddr(0), 32'h0);
        checkOutput("rst_prot_err", PROT_ERR, 0);
        stepCycle();
        ARESETn = 1'b1;

        // M0 four-beat read from memory with two ARREADY wait cycles.
        grantCheck(0);
        addrPhase(0, 32'h0000_0040, 4'd3, 2);
        serveBurst(0, 0, 4, 32'hA0);

        // Contention after reset: M0, then M1, then M0 again.
        ARESETn = 1'b0;
        stepCycle();
        ARESETn = 1'b1;
        applyStimulus(0, 1'b1, 32'h1000_0000, 4'd0);
        applyStimulus(1, 1'b1, 32'h0000_0100, 4'd0);
        grantCheck(0);
        addrPhase(1, 32'h1000_0000, 4'd0, 0);
        serveBurst(0, 1, 1, 32'hB0);
        grantCheck(1);
        addrPhase(0, 32'h0000_0100, 4'd0, 1);
        serveBurst(1, 0, 1, 32'hC0);
        applyStimulus(0, 1'b1, 32'h0000_0200, 4'd0);
        applyStimulus(1, 1'b1, 32'h1000_0100, 4'd0);
        grantCheck(0);
        applyStimulus(1, 1'b0, 32'h0, 4'h0);
        addrPhase(0, 32'h0000_0200, 4'd0, 0);
        serveBurst(0, 0, 1, 32'hC8);

        // Unmapped address: two DECERR beats with a three-cycle RREADY stall.
        applyStimulus(1, 1'b1, 32'h2000_0000, 4'd1);
        grantCheck(1);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("derr_stall_rvalid", mRvalid(1), 1);
            checkOutput("derr_stall_rlast", mRlast(1), 0);
            checkOutput("derr_no_s_arvalid", sArvalid(0) | sArvalid(1), 0);
            stepCycle();
        end
        setMasterRready(1, 1'b1);
        #1;
        checkOutput("derr_b1_rresp", mRresp(1), 2'b11);
        checkOutput("derr_b1_rdata", mRdata(1), 32'h0);
        checkOutput("derr_b1_rlast", mRlast(1), 0);
        checkOutput("derr_m0_rvalid", mRvalid(0), 0);
        stepCycle();
        #1;
        checkOutput("derr_b2_rvalid", mRvalid(1), 1);
        checkOutput("derr_b2_rresp", mRresp(1), 2'b11);
        checkOutput("derr_b2_rlast", mRlast(1), 1);
        stepCycle();
        setMasterRready(1, 1'b0);
        #1;
        checkOutput("derr_done_rvalid", mRvalid(1), 0);

        // Sixteen beats with M0 RREADY toggling every cycle.
        applyStimulus(0, 1'b1, 32'h0000_0000, 4'd15);
        grantCheck(0);
        addrPhase(0, 32'h0000_0000, 4'd15, 0);
        beat = 0;
        got = 0;
        for (int cyc = 0; cyc < 40 && beat < 16; cyc++) begin
            setMasterRready(0, cyc[0]);
            setSlaveR(0, 1'b1, 32'hD0 + beat, beat == 15);
            #1;
            checkOutput("toggle_rready_mirror", sRready(0), cyc[0]);
            checkOutput("toggle_rdata", mRdata(0), 32'hD0 + beat);
            checkOutput("toggle_rlast", mRlast(0), beat == 15);
            if (mRvalid(0) && cyc[0]) got++;
            stepCycle();
            if (cyc[0]) beat++;
        end
        setSlaveR(0, 1'b0, 32'h0, 1'b0);
        setMasterRready(0, 1'b0);
        checkOutput("toggle_beat_count", got, 16);
        #1;
        checkOutput("toggle_end_rvalid", mRvalid(0), 0);

        // Reset in the middle of an eight-beat burst, then a fresh M1 request.
        applyStimulus(0, 1'b1, 32'h0000_0300, 4'd7);
        grantCheck(0);
        addrPhase(0, 32'h0000_0300, 4'd7, 0);
        setMasterRready(0, 1'b1);
        setSlaveR(0, 1'b1, 32'hE0, 1'b0);
        #1;
        checkOutput("midrst_b1_rdata", mRdata(0), 32'hE0);
        stepCycle();
        setSlaveR(0, 1'b1, 32'hE1, 1'b0);
        ARESETn = 1'b0;
        #1;
        checkOutput("midrst_b2_rvalid", mRvalid(0), 1);
        stepCycle();
        ARESETn = 1'b1;
        #1;
        checkOutput("midrst_m0_rvalid", mRvalid(0), 0);
        checkOutput("midrst_m1_rvalid", mRvalid(1), 0);
        checkOutput("midrst_s0_arvalid", sArvalid(0), 0);
        checkOutput("midrst_s0_rready", sRready(0), 0);
        checkOutput("midrst_m0_arready", mArready(0), 0);
        setSlaveR(0, 1'b0, 32'h0, 1'b0);
        setMasterRready(0, 1'b0);
        applyStimulus(1, 1'b1, 32'h0000_0400, 4'd0);
        grantCheck(1);
        addrPhase(0, 32'h0000_0400, 4'd0, 0);
        serveBurst(1, 0, 1, 32'hF0);

`ifdef AXI3_RD_RLAST_GEN_EN
        // Slave raises RLAST early on beat 3; RLAST to M0 still comes on beat 4.
        applyStimulus(0, 1'b1, 32'h0000_0500, 4'd3);
        grantCheck(0);
        addrPhase(0, 32'h0000_0500, 4'd3, 0);
        setMasterRready(0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            setSlaveR(0, 1'b1, 32'hA0 + i, i == 2);
            #1;
            checkOutput("gen_rvalid", mRvalid(0), 1);
            checkOutput("gen_rlast", mRlast(0), i == 3);
            stepCycle();
            checkOutput("gen_prot_err", PROT_ERR, i >= 2);
        end
        setSlaveR(0, 1'b0, 32'h0, 1'b0);
        setMasterRready(0, 1'b0);
        #1;
        checkOutput("gen_end_rvalid", mRvalid(0), 0);
        stepCycle();
        stepCycle();
        checkOutput("gen_prot_err_sticky", PROT_ERR, 1);
`else
        checkOutput("prot_err_tied_low", PROT_ERR, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
